// File: rtl/stack_cpu_pkg.sv
// Shared types and constants for the stack CPU memory subsystem.
// Imported by the memory bus arbiter and its pick logic.
package stack_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    // Wide enough for any supported data width; truncated at the point of use.
    localparam logic [63:0] MEM_ERR_DATA = '1;

    function automatic logic req_active(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way requester pick: round-robin against last_grant,
// or fixed priority to the CPU when FIXED_PRI is set.
module rr_pick2
    import stack_cpu_pkg::*;
#(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       valid_o,
    output logic       id_o
);

    always_comb begin
        valid_o = |req_i;
        id_o    = REQ_CPU;
        case (req_i)
            2'b01:   id_o = REQ_CPU;
            2'b10:   id_o = REQ_LDR;
            2'b11:   id_o = FIXED_PRI ? REQ_CPU : ~last_grant_i;
            default: id_o = REQ_CPU;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the main-memory port between the CPU controller (req 0) and the
// loader/debug port (req 1), with a wait-state timeout against dead memory.
module mem_bus_arbiter
    import stack_cpu_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int TIMEOUT   = 255,
    parameter int FIXED_PRI = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_rd,
    input  logic          r0_wr,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_mfc,
    input  logic          r1_rd,
    input  logic          r1_wr,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_mfc,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_mfc,
    output logic          grant_id,
    output logic          busy,
    output logic          bus_error
);

    // Counter only has to reach TIMEOUT-1.
    localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [DW-1:0]   ERR_DATA = MEM_ERR_DATA[DW-1:0];

    arb_state_t    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          id_q, id_d;
    logic          wr_op_q, wr_op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    logic [1:0]    req;
    logic          pick_valid;
    logic          pick_id;

    assign req = {req_active(r1_rd, r1_wr), req_active(r0_rd, r0_wr)};

    rr_pick2 #(
        .FIXED_PRI (FIXED_PRI != 0)
    ) u_pick (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .id_o         (pick_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_LDR;
            id_q         <= REQ_CPU;
            wr_op_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            wr_op_q      <= wr_op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        wr_op_d      = wr_op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    id_d         = pick_id;
                    last_grant_d = pick_id;
                    addr_d       = pick_id ? r1_addr : r0_addr;
                    wdata_d      = pick_id ? r1_wdata : r0_wdata;
                    // rd and wr together resolve to a read.
                    wr_op_d      = pick_id ? (r1_wr & ~r1_rd) : (r0_wr & ~r0_rd);
                    cnt_d        = '0;
                    tmo_d        = 1'b0;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                if (mem_mfc) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    rdata_d = ERR_DATA;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                cnt_d   = '0;
                tmo_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-side and requester-side outputs decode purely from flops.
    assign busy      = (state_q == GRANT) || (state_q == DONE);
    assign grant_id  = busy & id_q;
    assign mem_rd    = (state_q == GRANT) & ~wr_op_q;
    assign mem_wr    = (state_q == GRANT) &  wr_op_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign r0_mfc    = (state_q == DONE) & (id_q == REQ_CPU);
    assign r1_mfc    = (state_q == DONE) & (id_q == REQ_LDR);
    assign r0_rdata  = r0_mfc ? rdata_q : '0;
    assign r1_rdata  = r1_mfc ? rdata_q : '0;
    assign bus_error = (state_q == DONE) & tmo_q;

endmodule
